// File: rtl/shift_pkg.sv
// shift_pkg: shared beat-mode encodings, widths and byte-acceptance helper for the shift blocks
package shift_pkg;
  localparam logic MODE_BIT = 1'b0;
  localparam logic MODE_BYTE = 1'b1;
  localparam int DEF_WIDTH = 64;
  localparam int BYTE_W = 8;
  function automatic logic byte_fits(input int cnt, input int width);
    return cnt <= width - BYTE_W;
  endfunction
endpackage

// File: rtl/shift_deser_out_stage.sv
// shift_deser_out_stage: 1-entry output holding register; ports: clk, reset, load/load_data/load_bits in, out_ready in, out_free/out_valid/out_data/out_bits out
module shift_deser_out_stage #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic [CNT_W-1:0] load_bits,
  input  logic             out_ready,
  output logic             out_free,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_bits
);
  assign out_free = !out_valid || out_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_bits <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data <= load_data;
      out_bits <= load_bits;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/shift_deser64.sv
// shift_deser64: MSB-first bit/byte stream to word deserializer; ports: clk, reset, in_valid/in_ready/in_mode/in_data, flush, out_valid/out_ready/out_data/out_bits
module shift_deser64 import shift_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [7:0]       in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_bits
);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(WIDTH);
  logic [WIDTH-1:0] acc, acc_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic is_byte, accept, emit, load, out_free;
  assign is_byte = in_mode == MODE_BYTE;
  assign in_ready = !flush && cnt < FULL && (is_byte ? byte_fits(int'(cnt), WIDTH) : 1'b1);
  assign accept = in_valid && in_ready;
  assign acc_n = is_byte ? {acc[WIDTH-9:0], in_data} : {acc[WIDTH-2:0], in_data[0]};
  assign cnt_n = cnt + (is_byte ? CNT_W'(BYTE_W) : CNT_W'(1));
  // A held full word, or a flushed partial one; bits above cnt are always zero, so acc needs no masking.
  assign emit = out_free && (cnt == FULL || (flush && cnt != '0));
  assign load = (accept && cnt_n == FULL && out_free) || emit;
  always_ff @(posedge clk) begin
    if (reset || load) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      acc <= acc_n;
      cnt <= cnt_n;
    end
  end
  shift_deser_out_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_out (
    .clk(clk),
    .reset(reset),
    .load(load),
    .load_data(accept ? acc_n : acc),
    .load_bits(accept ? FULL : cnt),
    .out_ready(out_ready),
    .out_free(out_free),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_bits(out_bits)
  );
endmodule

// File: tb/tb_shift_deser64.sv
// tb_shift_deser64: directed self-checking bench for shift_deser64
module tb_shift_deser64;
  logic clk = 0, reset = 1, in_valid = 0, in_mode = 0, flush = 0, out_ready = 0;
  logic [7:0] in_data = 0;
  logic in_ready, out_valid;
  logic [63:0] out_data;
  logic [6:0] out_bits;
  int errors = 0, checks = 0, stalls = 0, hs = 0, hs0;
  always #5 clk = ~clk;
  shift_deser64 dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_bits(out_bits)
  );
  always @(posedge clk) if (out_valid && out_ready) hs <= hs + 1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic beat(input logic m, input logic [7:0] d);
    int n = 0;
    in_valid = 1;
    in_mode = m;
    in_data = d;
    #1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) chk("beat_timeout", in_ready, 1);
    stalls += n;
    @(negedge clk);
    in_valid = 0;
  endtask
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    cycles(2);
    reset = 0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_bits", out_bits, 0);
    chk("rst_ready", in_ready, 1);
    @(negedge clk);
    out_ready = 1;
    stalls = 0;
    for (int i = 1; i <= 8; i++) beat(1, 8'(i));
    chk("byte_valid", out_valid, 1);
    chk("byte_data", out_data, 64'h0102030405060708);
    chk("byte_bits", out_bits, 64);
    chk("byte_nostall", stalls, 0);
    cycles(1);
    chk("byte_drain", out_valid, 0);
    for (int i = 0; i < 64; i++) beat(0, (i % 2 == 0) ? 8'hFE + 8'(i % 2 == 0) : 8'h00);
    chk("bit_valid", out_valid, 1);
    chk("bit_data", out_data, 64'hAAAAAAAAAAAAAAAA);
    chk("bit_bits", out_bits, 64);
    cycles(1);
    beat(0, 8'h01);
    for (int i = 0; i < 7; i++) beat(1, 8'hFF);
    in_valid = 1;
    in_mode = 1;
    in_data = 8'h55;
    #1;
    chk("mix_byte_stall", in_ready, 0);
    cycles(1);
    #1;
    chk("mix_byte_stall2", in_ready, 0);
    in_mode = 0;
    #1;
    chk("mix_bit_ok", in_ready, 1);
    for (int i = 0; i < 7; i++) beat(0, 8'hFE);
    chk("mix_valid", out_valid, 1);
    chk("mix_data", out_data, 64'hFFFFFFFFFFFFFF80);
    chk("mix_bits", out_bits, 64);
    cycles(1);
    out_ready = 0;
    for (int i = 0; i < 16; i++) beat(1, 8'(i));
    in_mode = 1;
    #1;
    chk("bp_byte_ready", in_ready, 0);
    in_mode = 0;
    #1;
    chk("bp_bit_ready", in_ready, 0);
    cycles(2);
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_hold_data", out_data, 64'h0001020304050607);
    hs0 = hs;
    out_ready = 1;
    cycles(1);
    chk("bp_w2_valid", out_valid, 1);
    chk("bp_w2_data", out_data, 64'h08090A0B0C0D0E0F);
    chk("bp_w2_bits", out_bits, 64);
    #1;
    chk("bp_ready_back", in_ready, 1);
    cycles(1);
    chk("bp_drain", out_valid, 0);
    chk("bp_hs", hs - hs0, 2);
    beat(1, 8'hAB);
    beat(1, 8'hCD);
    beat(1, 8'hEF);
    hs0 = hs;
    flush = 1;
    in_valid = 1;
    in_mode = 0;
    #1;
    chk("fl_ready", in_ready, 0);
    cycles(1);
    chk("fl_valid", out_valid, 1);
    chk("fl_data", out_data, 64'h0000000000ABCDEF);
    chk("fl_bits", out_bits, 24);
    cycles(2);
    #1;
    chk("fl_ready_held", in_ready, 0);
    flush = 0;
    in_valid = 0;
    cycles(1);
    chk("fl_once", hs - hs0, 1);
    chk("fl_idle", out_valid, 0);
    out_ready = 0;
    for (int i = 0; i < 13; i++) beat(1, 8'hC0 + 8'(i));
    chk("rm_pre_valid", out_valid, 1);
    reset = 1;
    cycles(1);
    reset = 0;
    chk("rm_valid", out_valid, 0);
    chk("rm_data", out_data, 0);
    chk("rm_bits", out_bits, 0);
    out_ready = 1;
    for (int i = 0; i < 8; i++) beat(1, 8'h11 + 8'(i));
    chk("rm_word", out_data, 64'h1112131415161718);
    chk("rm_word_bits", out_bits, 64);
    chk("rm_word_valid", out_valid, 1);
    cycles(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
